// File: rtl/duty_cycle_monitor.sv
// Duty-cycle monitor: measures period and high time of clk_mon in clk_in cycles and tracks lock.
// Define DUTY_MON_SYNC_EN to put a two-flop synchronizer in front of the sampling flop.
module duty_cycle_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 6,
    parameter int unsigned EXP_HIGH   = 2,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_clk_mon,
    output logic             o_meas_valid,
    output logic [CNT_W-1:0] o_period_out,
    output logic [CNT_W-1:0] o_high_out,
    output logic             o_locked,
    output logic             o_mismatch,
    output logic             o_timeout
);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ExpPeriod = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] ExpHigh   = CNT_W'(EXP_HIGH);
    localparam logic [3:0]       LockCnt   = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {StIdle, StArmed, StLocked} state_t;

    state_t           r_state;
    logic             r_smp;
    logic             r_prev;
    logic [CNT_W-1:0] r_cur_period;
    logic [CNT_W-1:0] r_cur_high;
    logic [3:0]       r_match_cnt;
    logic             r_meas_valid;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_locked;
    logic             r_mismatch;
    logic             r_timeout;

    logic             w_smp_d;
    logic             w_rise;
    logic             w_match;
    logic [3:0]       w_cnt_inc;

`ifdef DUTY_MON_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk_in or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_clk_mon};
        end
    end

    assign w_smp_d = r_sync[1];
`else
    assign w_smp_d = i_clk_mon;
`endif

    assign w_rise    = r_smp & ~r_prev;
    assign w_match   = (r_cur_period == ExpPeriod) && (r_cur_high == ExpHigh);
    assign w_cnt_inc = (r_match_cnt == 4'hF) ? 4'hF : r_match_cnt + 4'd1;

    // Counters run in every state; at a rise they still hold the finished period.
    always_ff @(posedge i_clk_in or posedge i_rst) begin
        if (i_rst) begin
            r_smp        <= 1'b0;
            r_prev       <= 1'b0;
            r_cur_period <= '0;
            r_cur_high   <= '0;
        end else begin
            r_smp  <= w_smp_d;
            r_prev <= r_smp;
            if (w_rise) begin
                r_cur_period <= CNT_W'(1);
                r_cur_high   <= CNT_W'(1);
            end else begin
                if (r_cur_period != CntMax) begin
                    r_cur_period <= r_cur_period + CNT_W'(1);
                end
                if (r_smp && (r_cur_high != CntMax)) begin
                    r_cur_high <= r_cur_high + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk_in or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_match_cnt  <= '0;
            r_meas_valid <= 1'b0;
            r_period     <= '0;
            r_high       <= '0;
            r_locked     <= 1'b0;
            r_mismatch   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_mismatch   <= 1'b0;
            r_timeout    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_locked <= 1'b0;
                    // First rise only starts a period; nothing to report yet.
                    if (w_rise) begin
                        r_state <= StArmed;
                    end
                end
                StArmed, StLocked: begin
                    if (w_rise) begin
                        r_meas_valid <= 1'b1;
                        r_period     <= r_cur_period;
                        r_high       <= r_cur_high;
                        if (w_match) begin
                            r_match_cnt <= w_cnt_inc;
                            if ((r_state == StLocked) || (w_cnt_inc == LockCnt)) begin
                                r_state  <= StLocked;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_mismatch  <= 1'b1;
                            r_match_cnt <= '0;
                            r_state     <= StArmed;
                            r_locked    <= 1'b0;
                        end
                    end else if (r_cur_period == CntMax) begin
                        r_timeout   <= 1'b1;
                        r_match_cnt <= '0;
                        r_state     <= StIdle;
                        r_locked    <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign o_meas_valid = r_meas_valid;
    assign o_period_out = r_period;
    assign o_high_out   = r_high;
    assign o_locked     = r_locked;
    assign o_mismatch   = r_mismatch;
    assign o_timeout    = r_timeout;

endmodule
